// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
//
// Sequences a 32-bit load/store from the MEM pipeline stage onto a byte-wide
// data RAM port. A word access takes four RAM cycles in big-endian order
// (byte 0 at the base address is bits [31:24]). A byte access takes one RAM
// cycle. The pipeline is frozen with `stall` while the access is running.
//
// Ports
//   clk       rising-edge clock
//   R         asynchronous active-low reset
//   req_E     access enable from the EX/MEM register
//   req_RW    0 = read, 1 = write
//   req_Size  0 = byte, 1 = word
//   req_A     byte address of the access
//   req_DI    store data
//   ram_A     RAM byte address
//   ram_WE    RAM byte write strobe
//   ram_DI    RAM write byte
//   ram_DO    RAM read byte (combinational from ram_A)
//   DO        assembled load data toward MEM/WB
//   stall     pipeline freeze (PC, IF/ID, ID/EX, EX/MEM)
//   done      one-cycle pulse when an access completes
// ---------------------------------------------------------------------------
module mem_access_seq (
    input  logic        clk,
    input  logic        R,
    input  logic        req_E,
    input  logic        req_RW,
    input  logic        req_Size,
    input  logic [7:0]  req_A,
    input  logic [31:0] req_DI,
    output logic [7:0]  ram_A,
    output logic        ram_WE,
    output logic [7:0]  ram_DI,
    input  logic [7:0]  ram_DO,
    output logic [31:0] DO,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;

    // Latched copy of the request; inputs are not looked at after acceptance.
    logic        rw_q;
    logic        size_q;
    logic [31:0] di_q;
    logic [7:0]  base_q;
    logic [31:0] do_q;

    logic        last_byte;
    logic [7:0]  wr_byte;

    assign last_byte = !size_q || (cnt == 2'd3);
    assign DO        = do_q;

    // Store byte for the current counter position, big-endian for words.
    always_comb begin
        wr_byte = di_q[7:0];
        if (size_q) begin
            case (cnt)
                2'd0:    wr_byte = di_q[31:24];
                2'd1:    wr_byte = di_q[23:16];
                2'd2:    wr_byte = di_q[15:8];
                default: wr_byte = di_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            rw_q   <= 1'b0;
            size_q <= 1'b0;
            di_q   <= 32'd0;
            base_q <= 8'd0;
            do_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_E) begin
                rw_q   <= req_RW;
                size_q <= req_Size;
                di_q   <= req_DI;
                // Word accesses are forced onto a 4-byte boundary so base+3
                // never wraps past 255.
                base_q <= req_Size ? {req_A[7:2], 2'b00} : req_A;
            end
            if (state == XFER && !rw_q) begin
                if (!size_q) begin
                    do_q <= {24'd0, ram_DO};
                end else begin
                    case (cnt)
                        2'd0:    do_q[31:24] <= ram_DO;
                        2'd1:    do_q[23:16] <= ram_DO;
                        2'd2:    do_q[15:8]  <= ram_DO;
                        default: do_q[7:0]   <= ram_DO;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_A     = base_q;
        ram_WE    = 1'b0;
        ram_DI    = 8'd0;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                stall = req_E;
                if (req_E) begin
                    state_nxt = XFER;
                    cnt_nxt   = 2'd0;
                end
            end
            XFER: begin
                stall  = 1'b1;
                ram_A  = base_q + {6'd0, cnt};
                ram_WE = rw_q;
                ram_DI = rw_q ? wr_byte : 8'd0;
                if (last_byte) begin
                    state_nxt = DONE;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            DONE: begin
                // stall low here lets EX/MEM retire the request; req_E is
                // ignored so the same request is not restarted.
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
